uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of uart_rx. It absorbs bytes from the receiver's rx_data/rx_valid/rx_ready handshake and stores them in a circular FIFO.
- Presents the bytes to the host side through a first-word-fall-through valid/ready interface.
- A serial line cannot be stalled, so the block always accepts input. When the FIFO is full, an incoming byte is dropped and the drop is flagged.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo_mem.sv | 25 ++
 rtl/uart_rx_fifo.sv | 96 +++++++++
 tb/tb_uart_rx_fifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, types and helpers for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DW            = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

  typedef logic [UART_DW-1:0] uart_byte_t;

  // Ceiling log2 that never returns 0, so a 1-entry address stays 1 bit wide.
  function automatic int unsigned clog2_safe(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH,
  parameter int unsigned DW    = UART_DW,
  parameter int unsigned AW    = clog2_safe(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive buffer behind uart_rx; accepts every byte and drops on full.
// Optional drop counter enabled by defining UART_RX_FIFO_DROPCNT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH,
  parameter int unsigned DW    = UART_DW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DW-1:0]              out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [15:0]                ovf_count
);

  localparam int unsigned AW = clog2_safe(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] occ;
  logic        push;
  logic        pop;
  logic        drop;
  logic        rdy_q;

  // Occupancy falls out of the extra pointer bit; no separate counter to keep in step.
  assign occ       = wr_ptr - rd_ptr;
  assign count     = CW'(occ);
  assign full      = (occ == (AW + 1)'(DEPTH));
  assign out_valid = (occ != '0);
  assign in_ready  = rdy_q;

  assign pop  = out_valid & out_ready;
  assign push = in_valid & rdy_q & (~full | pop);
  assign drop = in_valid & rdy_q & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef UART_RX_FIFO_DROPCNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (ovf_clr)               drop_cnt <= 16'd1;
      else if (drop_cnt != '1)   drop_cnt <= drop_cnt + 16'd1;
    end else if (ovf_clr) begin
      drop_cnt <= '0;
    end
  end

  assign ovf_count = drop_cnt;
`else
  assign ovf_count = '0;
`endif

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    count;
  logic          full;
  logic          overflow;
  logic          ovf_clr;
  logic [15:0]   ovf_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_ovf;
  int            m_drops;
  bit            m_rdy;

  uart_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_ovf_count();
`ifdef UART_RX_FIFO_DROPCNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string where);
    check({where, ".count"},     32'(count),     32'(q.size()));
    check({where, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    check({where, ".full"},      32'(full),      32'(q.size() == DEPTH));
    check({where, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({where, ".in_ready"},  32'(in_ready),  32'(m_rdy));
    check({where, ".ovf_count"}, 32'(ovf_count), 32'(exp_ovf_count()));
    if (q.size() != 0) check({where, ".out_data"}, 32'(out_data), 32'(q[0]));
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, then compare.
  task automatic cycle(input string where, input bit vld, input logic [DW-1:0] d,
                       input bit rdy, input bit clr);
    bit do_pop, do_push, do_drop, is_full;
    in_valid  = vld;
    in_data   = d;
    out_ready = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    is_full = (q.size() == DEPTH);
    do_pop  = rdy && (q.size() != 0);
    do_push = vld && m_rdy && (!is_full || do_pop);
    do_drop = vld && m_rdy && is_full && !do_pop;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
    if (do_drop) begin
      m_ovf = 1;
      if (clr)                m_drops = 1;
      else if (m_drops < 16'hFFFF) m_drops++;
    end else if (clr) begin
      m_ovf   = 0;
      m_drops = 0;
    end
    m_rdy = 1;
    #1;
    check_all(where);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 0;
    m_drops = 0;
    m_rdy   = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    rst_n = 1'b1;

    // First edge after release raises in_ready; a strobe there would be ignored.
    cycle("ready_rise", 1'b1, 8'h77, 1'b0, 1'b0);

    // Single byte
    cycle("single_push", 1'b1, 8'h55, 1'b0, 1'b0);
    check("single_data", 32'(out_data), 32'h55);
    cycle("single_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("empty_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Ordering and wrap-around with continuous popping
    for (int i = 0; i < 40; i++) cycle("stream", 1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)  cycle("stream_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill, then overflow on the 17th byte
    for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cycle("drop_aa", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("drop_full", 32'(full), 32'h1);
    // Full with simultaneous pop: accepted, not a drop
    cycle("full_push_pop", 1'b1, 8'hBB, 1'b1, 1'b0);
    // Clear racing a new drop: set wins
    cycle("clr_race", 1'b1, 8'hCC, 1'b0, 1'b1);
    cycle("clr_alone", 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 18; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("random", ($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) cycle("pre_reset", 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    rst_n = 1'b1;
    cycle("post_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("post_push", 1'b1, 8'h3C, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
